spi_frame_reader: RTL

SPI master that streams one compressed Bad Apple frame from external SPI flash into the video/decode pipeline. It consumes the SPI_clk_en strobe from clk_en_gen and issues a standard READ command (0x03) with a 24-bit address. It shifts in a programmed number of bytes and presents them one at a time on a valid/ready byte interface. All logic runs on CLK_40, and SPI_clk_en is used as an enable only; SCLK is a registered data output, never a clock.

---
 rtl/bad_apple_pkg.sv | 17 +
 rtl/spi_frame_reader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bad_apple_pkg.sv
// Shared definitions for the Bad Apple flash-to-video path.
// Holds the flash read opcode, the flash address width and the SPI reader state encoding.
package bad_apple_pkg;

  localparam logic [7:0] CMD_READ         = 8'h03;
  localparam int         FLASH_ADDR_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CS_SETUP   = 3'd1,
    SHIFT_CMD  = 3'd2,
    SHIFT_DATA = 3'd3,
    STALL      = 3'd4,
    CS_HOLD    = 3'd5
  } spi_rd_state_t;

endpackage

// File: rtl/spi_frame_reader.sv
// SPI master that reads one compressed frame from flash (READ 0x03 + address) and
// presents the received bytes one at a time on a valid/ready byte interface.
module spi_frame_reader
  import bad_apple_pkg::*;
#(
  parameter int ADDR_WIDTH = FLASH_ADDR_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  CLK_40,
  input  logic                  reset,
  input  logic                  SPI_clk_en,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  byte_count,
  input  logic                  abort,
  input  logic                  SPI_MISO,
  output logic                  SPI_SCLK,
  output logic                  SPI_CS_n,
  output logic                  SPI_MOSI,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done,
  output spi_rd_state_t         dbg_state
);

  // Byte handshake: a byte transfers on every CLK_40 edge where data_valid && data_ready;
  // data_valid stays high, with data_out stable, until that happens.

  localparam int TX_BITS = 8 + ADDR_WIDTH;
  localparam int CNT_W   = $clog2(TX_BITS);

  spi_rd_state_t          r_state;
  spi_rd_state_t          w_state_next;
  logic                   r_sclk;
  logic                   r_cs_n;
  logic [TX_BITS-1:0]     r_tx;
  logic [7:0]             r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [7:0]             r_data_out;
  logic                   r_data_valid;
  logic                   r_busy;
  logic                   r_done;

  logic w_rise;
  logic w_fall;
  logic w_cmd_last;
  logic w_bit7;
  logic w_room;
  logic w_accept;
  logic w_last;
  logic w_byte_done;
  logic w_load;
  logic w_abort;

  assign w_rise      = SPI_clk_en && !r_sclk;
  assign w_fall      = SPI_clk_en && r_sclk;
  assign w_cmd_last  = (r_bit_cnt == CNT_W'(TX_BITS - 1));
  assign w_bit7      = (r_bit_cnt == CNT_W'(7));
  assign w_room      = !r_data_valid || data_ready;
  assign w_accept    = r_data_valid && data_ready;
  assign w_last      = (r_remaining == LEN_WIDTH'(1));
  assign w_byte_done = (r_state == SHIFT_DATA) && w_fall && w_bit7;
  assign w_load      = (w_byte_done || (r_state == STALL)) && w_room;
  assign w_abort     = abort && (r_state != IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:       if (start && (byte_count != '0)) w_state_next = CS_SETUP;
      CS_SETUP:   if (SPI_clk_en) w_state_next = SHIFT_CMD;
      SHIFT_CMD:  if (w_fall && w_cmd_last) w_state_next = SHIFT_DATA;
      SHIFT_DATA: if (w_byte_done) w_state_next = !w_room ? STALL : (w_last ? CS_HOLD : SHIFT_DATA);
      STALL:      if (w_room) w_state_next = w_last ? CS_HOLD : SHIFT_DATA;
      CS_HOLD:    if (SPI_clk_en) w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
    if (w_abort) w_state_next = IDLE;
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_tx         <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_remaining  <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (w_accept) r_data_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            if (byte_count != '0) begin
              r_remaining <= byte_count;
              r_tx        <= {CMD_READ, start_addr};
              r_bit_cnt   <= '0;
              r_busy      <= 1'b1;
              r_cs_n      <= 1'b0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        SHIFT_CMD: begin
          // MOSI is the MSB of r_tx; the zero fill leaves MOSI low once the header is out.
          if (w_rise) begin
            r_sclk <= 1'b1;
          end else if (w_fall) begin
            r_sclk    <= 1'b0;
            r_tx      <= {r_tx[TX_BITS-2:0], 1'b0};
            r_bit_cnt <= w_cmd_last ? '0 : r_bit_cnt + CNT_W'(1);
          end
        end
        SHIFT_DATA: begin
          if (w_rise) begin
            r_sclk  <= 1'b1;
            r_shift <= {r_shift[6:0], SPI_MISO};
          end else if (w_fall) begin
            r_sclk    <= 1'b0;
            r_bit_cnt <= w_bit7 ? '0 : r_bit_cnt + CNT_W'(1);
          end
        end
        CS_HOLD: begin
          if (SPI_clk_en) begin
            r_cs_n <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_load) begin
        r_data_out   <= r_shift;
        r_data_valid <= 1'b1;
        r_remaining  <= r_remaining - LEN_WIDTH'(1);
      end

      if (w_abort) begin
        r_cs_n       <= 1'b1;
        r_sclk       <= 1'b0;
        r_tx         <= '0;
        r_bit_cnt    <= '0;
        r_data_valid <= 1'b0;
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
      end
    end
  end

  assign SPI_SCLK   = r_sclk;
  assign SPI_CS_n   = r_cs_n;
  assign SPI_MOSI   = r_tx[TX_BITS-1];
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule
